fetch_seq_ctrl: RTL

Sequences instruction-cache fetch requests for the frontend and decides the next fetch address. Priority order: backend redirect, then instruction-queue replay, then branch-predict redirect, then sequential fetch. Tracks in-flight I$ requests and discards stale responses after any redirect, so only a valid, in-order stream reaches the instruction queue. Sits between the frontend PC logic, the I$ request/response port and the instruction queue's ready/replay interface.

---
 rtl/fetch_seq_ctrl_pkg.sv | 28 ++
 rtl/fetch_seq_ctrl_if.sv | 29 ++
 rtl/fetch_seq_ctrl_inflight_cnt.sv | 60 ++++++
 rtl/fetch_seq_ctrl.sv | 116 +++++++++++
 4 files changed

// File: rtl/fetch_seq_ctrl_pkg.sv
// Shared frontend definitions for the fetch sequencer.
//   fetch_state_e   : sequencer FSM states
//   fetch_addr_t    : 64-bit fetch address
//   DEF_FETCH_BYTES : default packet size, derived from INSTR_PER_FETCH
//   DEF_BOOT_ADDR   : default first fetch address after reset
//   fetch_align()   : clears the packet-offset bits of an address
package fetch_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    FS_BOOT,
    FS_RUN,
    FS_HALTED
  } fetch_state_e;

  typedef logic [63:0] fetch_addr_t;

  localparam int unsigned INSTR_BYTES     = 4;
  localparam int unsigned INSTR_PER_FETCH = 1;
  localparam int unsigned DEF_FETCH_BYTES = INSTR_PER_FETCH * INSTR_BYTES;
  localparam fetch_addr_t DEF_BOOT_ADDR   = 64'h0000_0000_0001_0000;

  // fetch_bytes is a power of two, so the mask is a contiguous run of low bits.
  function automatic fetch_addr_t fetch_align(input fetch_addr_t addr,
                                              input int unsigned fetch_bytes);
    return addr & ~(64'(fetch_bytes) - 64'd1);
  endfunction

endpackage

// File: rtl/fetch_seq_ctrl_if.sv
// I$ request/response port of the fetch sequencer, including the branch
// prediction that travels with each response.
//   ic_req_valid / ic_req_ready / ic_req_addr : fetch request handshake
//   ic_kill      : kill pulse for in-flight requests
//   ic_rsp_valid : in-order response for the oldest accepted request
//   bp_valid / bp_addr : taken prediction qualified by ic_rsp_valid
// master = fetch sequencer side, slave = I$ side.
interface fetch_seq_ctrl_if;
  import fetch_seq_ctrl_pkg::*;

  logic        ic_req_valid;
  logic        ic_req_ready;
  fetch_addr_t ic_req_addr;
  logic        ic_kill;
  logic        ic_rsp_valid;
  logic        bp_valid;
  fetch_addr_t bp_addr;

  modport master (
    output ic_req_valid, ic_req_addr, ic_kill,
    input  ic_req_ready, ic_rsp_valid, bp_valid, bp_addr
  );

  modport slave (
    input  ic_req_valid, ic_req_addr, ic_kill,
    output ic_req_ready, ic_rsp_valid, bp_valid, bp_addr
  );

endinterface

// File: rtl/fetch_seq_ctrl_inflight_cnt.sv
// In-flight request bookkeeping: out_cnt counts accepted-but-unanswered I$
// requests, drop_cnt counts how many of those are stale (older than the last
// redirect) and must be discarded when they return.
//   inc_i       : request accepted this cycle
//   dec_i       : response consumed this cycle
//   drop_dec_i  : consumed response was stale
//   drop_load_i : every request still in flight after this cycle becomes stale
//   out_cnt_o / drop_cnt_o : registered counts
module fetch_inflight_cnt #(
  parameter  int unsigned MAX_OUTSTANDING = 2,
  localparam int unsigned CW              = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          inc_i,
  input  logic          dec_i,
  input  logic          drop_dec_i,
  input  logic          drop_load_i,
  output logic [CW-1:0] out_cnt_o,
  output logic [CW-1:0] drop_cnt_o
);

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    out_cnt_d  = out_cnt_q + CW'(inc_i) - CW'(dec_i);
    drop_cnt_d = drop_cnt_q;
    if (drop_load_i) begin
      drop_cnt_d = out_cnt_d;
    end else if (drop_dec_i) begin
      drop_cnt_d = drop_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign out_cnt_o  = out_cnt_q;
  assign drop_cnt_o = drop_cnt_q;

  a_cnt_bounds : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (drop_cnt_q <= out_cnt_q) && (out_cnt_q <= MAX_CNT));
  a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (inc_i && !dec_i) |-> (out_cnt_q < MAX_CNT));
  a_no_underflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
    dec_i |-> (out_cnt_q != '0));
  a_drop_underflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
    drop_dec_i |-> (drop_cnt_q != '0));

endmodule

// File: rtl/fetch_seq_ctrl.sv
// Frontend fetch sequencer. Issues I$ fetch requests, picks the next fetch
// address (backend redirect > IQ replay > branch prediction > sequential),
// and discards responses that belong to requests issued before a redirect.
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   redirect_valid_i/addr_i  : backend flush/redirect
//   halt_i                   : stop issuing requests (in-flight still complete)
//   ic                       : I$ request/response port (master side)
//   iq_ready_i               : instruction queue can take packets
//   replay_i/replay_addr_i   : IQ overflowed on the forwarded packet
//   fetch_valid_o            : forward current response to the IQ
//   outstanding_o            : in-flight request count
module fetch_seq_ctrl
  import fetch_seq_ctrl_pkg::*;
#(
  parameter  int unsigned FETCH_BYTES     = DEF_FETCH_BYTES,
  parameter  int unsigned MAX_OUTSTANDING = 2,
  parameter  fetch_addr_t BOOT_ADDR       = DEF_BOOT_ADDR,
  localparam int unsigned CW              = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               redirect_valid_i,
  input  fetch_addr_t        redirect_addr_i,
  input  logic               halt_i,
  fetch_seq_ctrl_if.master   ic,
  input  logic               iq_ready_i,
  input  logic               replay_i,
  input  fetch_addr_t        replay_addr_i,
  output logic               fetch_valid_o,
  output logic [CW-1:0]      outstanding_o
);

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  fetch_state_e  state_q, state_d;
  fetch_addr_t   npc_q, npc_d, npc_aligned;
  logic [CW-1:0] out_cnt_q, drop_cnt_q;

  logic redirect_act;
  logic rsp_fire;
  logic rsp_stale;
  logic fetch_valid;
  logic local_flush;
  logic req_valid;
  logic accept;

  fetch_inflight_cnt #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_inflight_cnt (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .inc_i       (accept),
    .dec_i       (rsp_fire),
    .drop_dec_i  (rsp_stale),
    .drop_load_i (redirect_act || local_flush),
    .out_cnt_o   (out_cnt_q),
    .drop_cnt_o  (drop_cnt_q)
  );

  assign npc_aligned = fetch_align(npc_q, FETCH_BYTES);

  always_comb begin
    redirect_act = redirect_valid_i && (state_q != FS_BOOT);
    // A response with nothing in flight is a protocol error and is ignored.
    rsp_fire     = ic.ic_rsp_valid && (out_cnt_q != '0);
    rsp_stale    = rsp_fire && (drop_cnt_q != '0);
    fetch_valid  = rsp_fire && !rsp_stale && !redirect_act && (state_q != FS_BOOT);
    local_flush  = fetch_valid && (replay_i || ic.bp_valid);
    // Request suppressed on any flush cycle, so drop_cnt can load out_cnt_d
    // without having to exclude a same-cycle accept.
    req_valid    = (state_q == FS_RUN) && !halt_i && iq_ready_i &&
                   (out_cnt_q < MAX_CNT) && !redirect_valid_i && !local_flush;
    accept       = req_valid && ic.ic_req_ready;

    npc_d = npc_q;
    if (redirect_act) begin
      npc_d = redirect_addr_i;
    end else if (fetch_valid && replay_i) begin
      npc_d = replay_addr_i;
    end else if (fetch_valid && ic.bp_valid) begin
      npc_d = ic.bp_addr;
    end else if (accept) begin
      npc_d = npc_aligned + 64'(FETCH_BYTES);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FS_BOOT:   state_d = FS_RUN;
      FS_RUN:    if (halt_i) state_d = FS_HALTED;
      FS_HALTED: if (!halt_i) state_d = FS_RUN;
      default:   state_d = FS_BOOT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= FS_BOOT;
      npc_q   <= BOOT_ADDR;
    end else begin
      state_q <= state_d;
      npc_q   <= npc_d;
    end
  end

  assign ic.ic_req_valid = req_valid;
  assign ic.ic_req_addr  = npc_aligned;
  assign ic.ic_kill      = redirect_act || local_flush;
  assign fetch_valid_o   = fetch_valid;
  assign outstanding_o   = out_cnt_q;

  a_rsp_with_inflight : assert property (@(posedge clk_i) disable iff (!rst_ni)
    ic.ic_rsp_valid |-> (out_cnt_q != '0));

endmodule
